uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte producers.
- Round-robin arbitration. Drives the transmitter's parallel data and load inputs, and monitors its status output to sequence one byte at a time.
- Sits between the producer blocks and the transmitter. Runs in the baud clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOAD_TIMEOUT, 15, max bclk cycles tx_load may stay high without tx_status falling before the byte is aborted.

Ports:
- bclk  input  1  baud clock; all logic on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester byte request; level, held until ack or err
- req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i]; stable while req[i]=1
- ack  output  NUM_REQ  one-cycle pulse: granted byte captured by transmitter
- done  output  1  one-cycle pulse: granted byte's frame finished
- err_timeout  output  1  one-cycle pulse: load aborted after LOAD_TIMEOUT
- grant_id  output  3  index of current/last granted requester
- busy  output  1  high in any state other than IDLE
- tx_status  input  1  transmitter ready (1) / transmitting (0)
- tx_load  output  1  load strobe to transmitter
- tx_data  output  8  byte to transmitter

Behaviour:
- Reset (async, reset_n=0): state=IDLE, ack=0, done=0, err_timeout=0, tx_load=0, tx_data=8'h00, grant_id=0, busy=0, rr_ptr=0, timeout counter=0. A reset mid-frame abandons the byte with no ack or done. The transmitter finishes or resets on its own.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req bit is set and tx_status=1, pick the first set req at or after rr_ptr, scanning upward and wrapping.
  - Register grant_id and tx_data=req_data[grant], set tx_load=1, go to LOAD.
  - If tx_status=0, stay in IDLE (transmitter still busy from an external source or reset).
- LOAD:
  - Hold tx_load=1 and tx_data constant; count cycles.
  - When tx_status=0 is sampled: tx_load=0, ack[grant_id]=1 for one cycle, go to WAIT_DONE.
  - If the count reaches LOAD_TIMEOUT with tx_status still 1: tx_load=0, err_timeout=1 for one cycle, no ack, rr_ptr=grant_id+1 mod NUM_REQ, go to IDLE.
- WAIT_BUSY: reserved transitional state. On entry go straight to WAIT_DONE. Illegal or unused encodings also return to IDLE with all strobes low.
- WAIT_DONE:
  - Wait for tx_status=1.
  - Then done=1 for one cycle, rr_ptr=grant_id+1 mod NUM_REQ, go to IDLE.
- Back-to-back traffic: a new grant may start in the cycle after done, provided tx_status=1.
- Latency: grant to tx_load is 1 cycle after req is sampled in IDLE.
- Requests: req deasserted after grant is ignored; the byte already latched is sent. A requester must not drop req before ack unless err_timeout is seen.
- Simultaneous requests resolve purely by rr_ptr. A single persistent requester is granted every slot.
- grant_id holds its value after done, until the next grant.
- ack, done and err_timeout are never asserted in the same cycle.

Optional Feature:
- UART_ARB_PRIO0_EN defined: requester 0 has fixed highest priority. If req[0]=1 in IDLE it wins regardless of rr_ptr, and rr_ptr is not updated after a requester-0 grant. Remaining requesters use round-robin among themselves.
- Undefined: pure round-robin over all requesters, as described above.

Test Plan:
- Single byte: req[2]=1, req_data[23:16]=8'hA5, transmitter model idle.
  - Required: tx_load=1 with tx_data=8'hA5 one cycle later.
  - ack[2] pulses when tx_status falls; done pulses when tx_status rises; grant_id=2; serial line shows start bit, A5 LSB-first, stop bit.
- Round-robin: req=4'b1111 held continuously, distinct bytes 8'h10..8'h13.
  - Required: grant order 0,1,2,3,0; each byte transmitted exactly once per ack.
- Timeout: tx_status forced to 1 and load ignored, req[1]=1.
  - Required: tx_load high for exactly 15 cycles, then err_timeout pulse, no ack or done, next grant starts from requester 2.
- Busy transmitter: tx_status=0 at request time.
  - Required: no tx_load until tx_status=1; then grant proceeds normally.
- Reset mid-frame: assert reset_n=0 during WAIT_DONE.
  - Required: all outputs go to their reset values immediately (asynchronously); no done pulse; after release, a pending req is granted from rr_ptr=0.
- With UART_ARB_PRIO0_EN: req=4'b1011 held.
  - Required: requester 0 is granted every slot. After req[0] drops, grants alternate 1,3,1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte producers, one byte at a time.
// Optional build macro UART_ARB_PRIO0_EN gives requester 0 fixed highest priority over the round-robin.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic                   bclk,
    input  logic                   reset_n,
    // req[i] is a level held by producer i until ack[i] (byte taken) or err_timeout (byte dropped);
    // req_data slice i must stay stable while req[i] is high.
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   done,
    output logic                   err_timeout,
    output logic [2:0]             grant_id,
    output logic                   busy,
    input  logic                   tx_status,
    output logic                   tx_load,
    output logic [7:0]             tx_data
);

    localparam int CNT_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;

    logic [2:0]         r_state;
    logic [2:0]         r_ptr;
    logic [2:0]         r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_done;
    logic               r_err;
    logic               r_load;
    logic [7:0]         r_data;

    logic [NUM_REQ-1:0] w_req_rr;
    logic [3:0]         w_rr_pick;
    logic               w_found;
    logic [2:0]         w_sel;
    logic [7:0]         w_sel_data;
    logic [NUM_REQ-1:0] w_ack_hot;
    logic [2:0]         w_ptr_inc;
    logic [2:0]         w_ptr_after;

    // First set bit at or after ptr, wrapping; returns {found, index}.
    function automatic logic [3:0] f_pick(input logic [NUM_REQ-1:0] reqs, input logic [2:0] ptr);
        logic [3:0] res;
        int         idx;
        res = 4'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (reqs[idx]) res = {1'b1, idx[2:0]};
        end
        return res;
    endfunction

`ifdef UART_ARB_PRIO0_EN
    assign w_req_rr = {req[NUM_REQ-1:1], 1'b0};
`else
    assign w_req_rr = req;
`endif

    assign w_rr_pick = f_pick(w_req_rr, r_ptr);

    always_comb begin
        w_found = w_rr_pick[3];
        w_sel   = w_rr_pick[2:0];
`ifdef UART_ARB_PRIO0_EN
        if (req[0]) begin
            w_found = 1'b1;
            w_sel   = 3'd0;
        end
`endif
    end

    always_comb begin
        w_sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == 3'(i)) w_sel_data = req_data[8*i +: 8];
        end
    end

    always_comb begin
        w_ack_hot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ack_hot[i] = (r_grant == 3'(i));
        end
    end

    assign w_ptr_inc = (r_grant == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant + 3'd1;

`ifdef UART_ARB_PRIO0_EN
    // Requester 0 grants leave the round-robin position of the others untouched.
    assign w_ptr_after = (r_grant == 3'd0) ? r_ptr : w_ptr_inc;
`else
    assign w_ptr_after = w_ptr_inc;
`endif

    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'd0;
            r_grant <= 3'd0;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_load  <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_ack  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found && tx_status) begin
                        r_grant <= w_sel;
                        r_data  <= w_sel_data;
                        r_load  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // A falling tx_status means the transmitter took the byte; it wins over timeout.
                    if (!tx_status) begin
                        r_load  <= 1'b0;
                        r_ack   <= w_ack_hot;
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_load  <= 1'b0;
                        r_err   <= 1'b1;
                        r_ptr   <= w_ptr_after;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_BUSY: begin
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (tx_status) begin
                        r_done  <= 1'b1;
                        r_ptr   <= w_ptr_after;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_load  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack         = r_ack;
    assign done        = r_done;
    assign err_timeout = r_err;
    assign grant_id    = r_grant;
    assign busy        = (r_state != S_IDLE);
    assign tx_load     = r_load;
    assign tx_data     = r_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART transmitter, serial receiver, event-level reference
// arbiter, a table of arbitration vectors, directed corner sequences and a random phase.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic        bclk;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        done;
    logic        err_timeout;
    logic [2:0]  grant_id;
    logic        busy;
    logic        tx_status;
    logic        tx_load;
    logic [7:0]  tx_data;

    uart_tx_arbiter #(.NUM_REQ(N), .LOAD_TIMEOUT(TO)) dut (
        .bclk        (bclk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .done        (done),
        .err_timeout (err_timeout),
        .grant_id    (grant_id),
        .busy        (busy),
        .tx_status   (tx_status),
        .tx_load     (tx_load),
        .tx_data     (tx_data)
    );

    // clock / reset
    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // transmitter model state
    logic       serial;
    bit         force_ready;
    bit         hold_busy;
    int         m_cnt;
    logic [7:0] m_shift;
    int         m_frames;

    // reference arbiter / scoreboard state
    logic [7:0] exp_q[$];
    int         grant_log[$];
    int         model_ptr;
    int         pend_g;
    logic [7:0] pend_d;
    bit         pend_acked;
    bit         prev_load;
    int         load_cnt;
    int         n_ack;
    int         n_done;
    int         n_err;

    function automatic int model_pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic monitor_step();
        int g;
        if (!reset_n) begin
            model_ptr = 0;
            pend_g    = -1;
            prev_load = 1'b0;
            load_cnt  = 0;
            return;
        end
        if (tx_load && !prev_load) begin
            g = model_pick(req, model_ptr);
            check("grant_id", 32'(grant_id), 32'(g));
            if (g >= 0) begin
                check("grant_data", 32'(tx_data), 32'(req_data[8*g +: 8]));
                pend_d = req_data[8*g +: 8];
            end
            pend_g     = g;
            pend_acked = 1'b0;
            load_cnt   = 0;
            grant_log.push_back(int'(grant_id));
        end
        if (tx_load) load_cnt++;
        if ((|ack) || done || err_timeout)
            check("strobe_excl", 32'(int'(|ack) + int'(done) + int'(err_timeout)), 32'd1);
        if (|ack) begin
            n_ack++;
            check("ack_vec", 32'(ack), (pend_g >= 0 && !pend_acked) ? (32'd1 << pend_g) : 32'd0);
            pend_acked = 1'b1;
            exp_q.push_back(pend_d);
        end
        if (done) begin
            n_done++;
            check("done_after_ack", 32'(pend_g >= 0 && pend_acked), 32'd1);
            if (pend_g >= 0) model_ptr = (pend_g + 1) % N;
            pend_g = -1;
        end
        if (err_timeout) begin
            n_err++;
            check("timeout_len", 32'(load_cnt), 32'(TO));
            check("err_no_ack", 32'(pend_g >= 0 && !pend_acked), 32'd1);
            if (pend_g >= 0) model_ptr = (pend_g + 1) % N;
            pend_g = -1;
        end
        prev_load = tx_load;
    endtask

    // One bit per bclk: start, 8 data LSB-first, stop; status returns high after the stop bit.
    task automatic xmit_step();
        if (m_cnt == 0) begin
            if (force_ready) begin
                tx_status = 1'b1;
            end else if (hold_busy) begin
                tx_status = 1'b0;
            end else if (tx_load) begin
                m_shift   = tx_data;
                m_cnt     = 10;
                serial    = 1'b0;
                tx_status = 1'b0;
                m_frames++;
            end else begin
                tx_status = 1'b1;
            end
        end else begin
            m_cnt--;
            if (m_cnt >= 2) begin
                serial  = m_shift[0];
                m_shift = m_shift >> 1;
            end else if (m_cnt == 1) begin
                serial = 1'b1;
            end else begin
                serial    = 1'b1;
                tx_status = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge bclk);
            monitor_step();
            xmit_step();
        end
    end

    // serial receiver, sampling mid-bit on the rising edge
    logic [7:0] rx_byte;
    logic [7:0] rx_last;
    logic [7:0] rx_exp;
    int         rx_count;

    initial begin
        forever begin
            @(posedge bclk);
            if (serial == 1'b0) begin
                for (int k = 0; k < 8; k++) begin
                    @(posedge bclk);
                    rx_byte[k] = serial;
                end
                @(posedge bclk);
                check("rx_stop", 32'(serial), 32'd1);
                rx_last = rx_byte;
                rx_count++;
                check("rx_expected_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    rx_exp = exp_q.pop_front();
                    check("rx_byte", 32'(rx_byte), 32'(rx_exp));
                end
            end
        end
    end

    // driver tasks
    localparam int EV_ACK  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_LOAD = 3;
    localparam int EV_IDLE = 4;

    task automatic wait_sig(input int which, input int max_cyc, input string name);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < max_cyc && !hit; c++) begin
            @(negedge bclk);
            case (which)
                EV_ACK:  hit = |ack;
                EV_DONE: hit = done;
                EV_ERR:  hit = err_timeout;
                EV_LOAD: hit = tx_load;
                default: hit = !busy;
            endcase
        end
        if (!hit) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_%s: got no event in %0d cycles, expected event", name, max_cyc);
        end
    endtask

    task automatic step();
        @(negedge bclk);
        #1;
    endtask

    typedef struct {
        logic [3:0] req;
        int         exp_grant;
    } vec_t;

    vec_t tbl[8];
    int   exp_rr[5];
    int   a0, d0, r0;
    int   bound;
    bit   load_seen;

    initial begin
        // arbitration vectors chained from rr_ptr=0 after reset
        tbl[0] = '{4'b0100, 2};
        tbl[1] = '{4'b1001, 3};
        tbl[2] = '{4'b0110, 1};
        tbl[3] = '{4'b0011, 0};
        tbl[4] = '{4'b1000, 3};
        tbl[5] = '{4'b1111, 0};
        tbl[6] = '{4'b0001, 0};
        tbl[7] = '{4'b1101, 2};
        exp_rr = '{0, 1, 2, 3, 0};

        n_checks = 0; n_errors = 0;
        reset_n = 1'b0; req = 4'b0; req_data = 32'h0;
        tx_status = 1'b1; serial = 1'b1; force_ready = 1'b0; hold_busy = 1'b0;
        m_cnt = 0; m_frames = 0; rx_count = 0;
        model_ptr = 0; pend_g = -1; pend_acked = 1'b0; prev_load = 1'b0; load_cnt = 0;
        n_ack = 0; n_done = 0; n_err = 0;

        repeat (3) @(negedge bclk);
        check("reset_outputs", {17'h0, ack, done, err_timeout, grant_id, busy, tx_load, tx_data}, 32'h0);
        #1 reset_n = 1'b1;
        step();

        // table-driven arbitration
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < N; j++) req_data[8*j +: 8] = 8'((i << 4) | j);
            req = tbl[i].req;
            wait_sig(EV_LOAD, 20, "tbl_load");
            check("tbl_grant", 32'(grant_id), 32'(tbl[i].exp_grant));
            check("tbl_data", 32'(tx_data), 32'((i << 4) | tbl[i].exp_grant));
            wait_sig(EV_ACK, 20, "tbl_ack");
            check("tbl_ack", 32'(ack), 32'd1 << tbl[i].exp_grant);
            wait_sig(EV_DONE, 40, "tbl_done");
            #1 req = 4'b0;
        end

        // single byte: load one cycle after the request, then serial frame
        step();
        req_data[23:16] = 8'hA5;
        r0 = rx_count;
        req = 4'b0100;
        @(negedge bclk);
        check("a5_load_latency", {22'h0, busy, tx_load, tx_data}, {22'h0, 1'b1, 1'b1, 8'hA5});
        check("a5_grant", 32'(grant_id), 32'd2);
        wait_sig(EV_ACK, 20, "a5_ack");
        check("a5_ack", 32'(ack), 32'b0100);
        #1 req = 4'b0;
        wait_sig(EV_DONE, 40, "a5_done");
        bound = 0;
        while (rx_count == r0 && bound < 40) begin
            @(negedge bclk);
            bound++;
        end
        check("a5_serial", 32'(rx_last), 32'hA5);

        // busy transmitter: nothing loads until status rises
        step();
        hold_busy = 1'b1;
        step();
        step();
        req_data[31:24] = 8'h5C;
        req = 4'b1000;
        load_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge bclk);
            if (tx_load) load_seen = 1'b1;
        end
        check("busy_no_load", 32'(load_seen), 32'd0);
        #1 hold_busy = 1'b0;
        wait_sig(EV_LOAD, 10, "busy_load");
        check("busy_grant", 32'(grant_id), 32'd3);
        wait_sig(EV_ACK, 20, "busy_ack");
        #1 req = 4'b0;
        wait_sig(EV_DONE, 40, "busy_done");

        // round-robin with all four held
        step();
        grant_log.delete();
        req_data = 32'h13121110;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_sig(EV_ACK, 40, "rr_ack");
        #1 req = 4'b0;
        wait_sig(EV_DONE, 40, "rr_done");
        check("rr_count", 32'(grant_log.size()), 32'd5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) check("rr_order", 32'(grant_log[k]), 32'(exp_rr[k]));

        // load timeout
        step();
        force_ready = 1'b1;
        step();
        a0 = n_ack; d0 = n_done;
        req_data[15:8] = 8'h77;
        req = 4'b0010;
        wait_sig(EV_ERR, 40, "to_err");
        check("to_no_ack_done", 32'((n_ack - a0) + (n_done - d0)), 32'd0);
        #1 force_ready = 1'b0;
        req_data = 32'h00332211;
        req = 4'b0111;
        wait_sig(EV_LOAD, 10, "to_next_load");
        check("to_next_grant", 32'(grant_id), 32'd2);
        wait_sig(EV_ACK, 20, "to_next_ack");
        #1 req = 4'b0;
        wait_sig(EV_DONE, 40, "to_next_done");

        // reset during WAIT_DONE
        step();
        req_data[23:16] = 8'h3C;
        req = 4'b0100;
        wait_sig(EV_ACK, 20, "rst_ack");
        step();
        step();
        d0 = n_done;
        reset_n = 1'b0;
        #1;
        check("rst_async", {17'h0, ack, done, err_timeout, grant_id, busy, tx_load, tx_data}, 32'h0);
        req_data = 32'h9A00_8A00;
        req = 4'b1010;
        step();
        step();
        reset_n = 1'b1;
        wait_sig(EV_LOAD, 30, "rst_load");
        check("rst_no_done", 32'(n_done - d0), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd1);
        wait_sig(EV_ACK, 20, "rst_ack2");
        #1 req = 4'b0;
        wait_sig(EV_DONE, 40, "rst_done2");

        // random traffic against the reference model
        for (int c = 0; c < 2500; c++) begin
            step();
            for (int j = 0; j < N; j++) begin
                if (req[j] && ack[j]) begin
                    req[j] = 1'b0;
                end else if (!req[j] && $urandom_range(0, 7) == 0) begin
                    req_data[8*j +: 8] = 8'($urandom_range(0, 255));
                    req[j] = 1'b1;
                end
            end
        end
        bound = 0;
        while (req != 4'b0 && bound < 1000) begin
            step();
            for (int j = 0; j < N; j++) if (ack[j]) req[j] = 1'b0;
            bound++;
        end
        check("rand_drained", 32'(req), 32'd0);
        wait_sig(EV_IDLE, 40, "rand_idle");
        repeat (20) @(negedge bclk);

        check("frames_eq_acks", 32'(m_frames), 32'(n_ack));
        check("rx_eq_acks", 32'(rx_count), 32'(n_ack));
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("timeouts_seen", 32'(n_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: got no finish by 1ms, expected finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
